// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: FSM states, NOP encoding
// and the PC alignment/increment helpers.
package instruction_fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Instruction addresses are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage
// (master) and instruction memory (slave).
interface instruction_fetch_stage_if;
    import instruction_fetch_stage_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: flush beats stall, stall beats a new load, and an
// idle cycle inserts a bubble.
module if_id_register
    import instruction_fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instruction,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] instruction
);

    // pc/pc_plus4 are left untouched on flush and bubble; only valid and
    // instruction describe whether the slot is real.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid       <= 1'b0;
            pc          <= '0;
            pc_plus4    <= 32'd4;
            instruction <= NOP_INSTR;
        end else if (flush) begin
            valid       <= 1'b0;
            instruction <= NOP_INSTR;
        end else if (stall) begin
            valid       <= valid;
            instruction <= instruction;
        end else if (load) begin
            valid       <= 1'b1;
            pc          <= load_pc;
            pc_plus4    <= next_pc(load_pc);
            instruction <= load_instruction;
        end else begin
            valid       <= 1'b0;
            instruction <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// RV32I fetch stage: owns the PC, keeps at most one instruction-memory request
// in flight and feeds the IF/ID register, honouring stall and redirect.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_stage_if.master imem,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      if_id_valid,
    output logic [XLEN-1:0]           if_id_pc,
    output logic [XLEN-1:0]           if_id_pc_plus4,
    output logic [XLEN-1:0]           if_id_instruction
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] buffer;
    logic [XLEN-1:0] buffer_next;
    logic            load;
    logic [XLEN-1:0] load_instruction;
    logic            handshake;

    // Request outputs come straight from registered state so memory never
    // sees a combinational path from stall/redirect.
    assign imem.imem_req_valid = (state == FETCH);
    assign imem.imem_req_addr  = pc;
    assign handshake           = imem.imem_req_valid && imem.imem_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= align_pc(RESET_PC);
            buffer <= NOP_INSTR;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            buffer <= buffer_next;
        end
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        buffer_next      = buffer;
        load             = 1'b0;
        load_instruction = imem.imem_resp_data;

        // Responses seen in FETCH or HOLD cannot belong to us and are ignored.
        unique case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_next = align_pc(redirect_pc);
                    if (handshake) begin
                        state_next = DRAIN;
                    end
                end else if (handshake) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_next    = align_pc(redirect_pc);
                    state_next = imem.imem_resp_valid ? FETCH : DRAIN;
                end else if (imem.imem_resp_valid) begin
                    if (stall) begin
                        buffer_next = imem.imem_resp_data;
                        state_next  = HOLD;
                    end else begin
                        load       = 1'b1;
                        pc_next    = next_pc(pc);
                        state_next = FETCH;
                    end
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = align_pc(redirect_pc);
                    state_next = FETCH;
                end else if (!stall) begin
                    load             = 1'b1;
                    load_instruction = buffer;
                    pc_next          = next_pc(pc);
                    state_next       = FETCH;
                end
            end

            DRAIN: begin
                if (redirect_valid) begin
                    pc_next = align_pc(redirect_pc);
                end
                if (imem.imem_resp_valid) begin
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    if_id_register u_if_id_register (
        .clk              (clk),
        .reset            (reset),
        .flush            (redirect_valid),
        .stall            (stall),
        .load             (load),
        .load_pc          (pc),
        .load_instruction (load_instruction),
        .valid            (if_id_valid),
        .pc               (if_id_pc),
        .pc_plus4         (if_id_pc_plus4),
        .instruction      (if_id_instruction)
    );

    pc_aligned_check: assert property (@(posedge clk) disable iff (reset) pc[1:0] == 2'b00);

    single_request_check: assert property (@(posedge clk) disable iff (reset)
        (state == WAIT || state == DRAIN) |-> !imem.imem_req_valid);

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the pipelined RV32I core: owns the PC, issues one instruction-memory request at a time over a valid/ready handshake, and delivers fetched words into the IF/ID pipeline register that feeds decode and immediate generation. Honours stall from the hazard unit and redirect/flush from branch/jump resolution. At most one memory request is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  32  word-aligned fetch address (= pc)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_resp_valid  in  1  response data valid (exactly one per accepted request, ≥1 cycle after acceptance)
- imem_resp_data  in  32  instruction word
- stall  in  1  hazard unit: hold IF/ID contents
- redirect_valid  in  1  taken branch/JAL/JALR from EX: flush and refetch
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 00)
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  PC of IF/ID instruction
- if_id_pc_plus4  out  32  if_id_pc + 4, mod 2^32
- if_id_instruction  out  32  instruction word; NOP (32'h0000_0013) when invalid

## Operation
- States: FETCH, WAIT, HOLD, DRAIN. Reset → FETCH, pc = RESET_PC.
- FETCH: imem_req_valid=1, addr=pc. Handshake & !redirect → WAIT. Redirect & no handshake → pc←redirect_pc, stay FETCH. Redirect & handshake → pc←redirect_pc, DRAIN (wrong-path request in flight).
- WAIT: imem_req_valid=0. Redirect & !resp → pc←redirect_pc, DRAIN. Redirect & resp → discard, pc←redirect_pc, FETCH. Resp & !stall → load IF/ID {pc, data}, pc←pc+4, FETCH. Resp & stall → capture into one-entry buffer, HOLD.
- HOLD: redirect → drop buffer, pc←redirect_pc, FETCH. !stall → buffer → IF/ID, pc←pc+4, FETCH. Else hold.
- DRAIN: resp → discard, FETCH. Redirect → pc←redirect_pc, stay DRAIN.
- IF/ID update priority: redirect (valid←0, instruction←NOP) > stall (hold all) > new instruction delivered (load, valid←1) > otherwise bubble (valid←0, instruction←NOP).
- pc+4 wraps 32'hFFFF_FFFC → 0. pc[1:0] always 00.
- Responses arriving outside WAIT/DRAIN are a protocol violation; ignored.

## Timing
- Reset values: imem_req_valid=1 (FETCH), imem_req_addr=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=4, if_id_instruction=NOP. Reset mid-operation returns immediately to these; memory is reset by the same signal.
- imem_req_valid/addr are functions of registered state/pc only (no combinational path from inputs).
- Latency: request accepted edge N, response in cycle N+k → IF/ID valid after edge N+k. Zero-wait memory (ready=1, k=1): one instruction every 2 cycles.
- Redirect takes effect at the edge it is sampled; next FETCH presents redirect_pc the following cycle.

## Structure
- Shared core package: state enum (FETCH/WAIT/HOLD/DRAIN), NOP_INSTR = 32'h0000_0013, default RESET_PC, XLEN = 32.
- One natural sub-module: if_id_register (valid/pc/pc_plus4/instruction with flush/stall/load priority). FSM and pc in the top module.

## Test plan
- Reset: assert reset async mid-cycle → imem_req_valid=1, addr=0x0, if_id_valid=0, if_id_instruction=0x00000013 immediately.
- Streaming, ready=1, k=1, memory returns 0x00500093/0x00A00113/0x002081B3 at 0/4/8 → IF/ID valid with pc 0,4,8 on every second edge; pc_plus4 4,8,12.
- Stall: resp 0x00500093 arrives in WAIT with stall=1 for 3 cycles → IF/ID unchanged, no new request; stall drops → IF/ID loads pc 0 word next edge, then request addr 0x4.
- Redirect in WAIT to 0x103 before resp → if_id_valid=0, late resp discarded, next request addr 0x100.
- Redirect and stall asserted same cycle while IF/ID valid → flush wins: if_id_valid=0, instruction=NOP.
- Wrap: RESET_PC=0xFFFFFFFC, one fetch → if_id_pc_plus4=0x0, next request addr 0x0.
